// File: rtl/game_tick_scheduler.sv
// Clock-enable tick generator for hero and game logic, with run/pause/step
// control, a frame counter, and a valid/ready port for changing tick periods.
module game_tick_scheduler #(
  parameter int CNT_W        = 24,
  parameter int HERO_DIV_DEF = 2500000,
  parameter int GAME_DIV_DEF = 1000000,
  parameter int FRAME_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  input  logic               cfg_valid,
  input  logic               cfg_sel,
  input  logic [CNT_W-1:0]   cfg_div,
  output logic               cfg_ready,
  output logic               tick_hero,
  output logic               tick_game,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [1:0]         state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] STEP  = 2'd3;

  logic [CNT_W-1:0] cnt_hero;
  logic [CNT_W-1:0] cnt_game;
  logic [CNT_W-1:0] div_hero;
  logic [CNT_W-1:0] div_game;
  logic [CNT_W-1:0] cfg_div_clamped;
  logic [1:0]       state_nxt;
  logic             cfg_fire;
  logic             step_enter;
  logic             wrap_hero;
  logic             wrap_game;

  // Handshake: a transfer happens on any rising edge where cfg_valid and
  // cfg_ready are both 1; the requester holds cfg_sel/cfg_div stable until then.
  assign cfg_ready       = (state == IDLE) || (state == PAUSE);
  assign cfg_fire        = cfg_valid && cfg_ready;
  assign step_enter      = (state == PAUSE) && !run && step;
  assign wrap_hero       = (cnt_hero == div_hero - CNT_W'(1));
  assign wrap_game       = (cnt_game == div_game - CNT_W'(1));
  assign cfg_div_clamped = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = RUN;
      RUN:     if (!run) state_nxt = PAUSE;
      PAUSE: begin
        if (run)       state_nxt = RUN;
        else if (step) state_nxt = STEP;
      end
      default: state_nxt = PAUSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt_hero  <= '0;
      cnt_game  <= '0;
      div_hero  <= CNT_W'(HERO_DIV_DEF);
      div_game  <= CNT_W'(GAME_DIV_DEF);
      tick_hero <= 1'b0;
      tick_game <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      tick_hero <= 1'b0;
      tick_game <= 1'b0;

      if (state == RUN) begin
        if (wrap_hero) begin
          cnt_hero  <= '0;
          tick_hero <= 1'b1;
        end else begin
          cnt_hero <= cnt_hero + CNT_W'(1);
        end
        if (wrap_game) begin
          cnt_game  <= '0;
          tick_game <= 1'b1;
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end else begin
          cnt_game <= cnt_game + CNT_W'(1);
        end
      end

      if (cfg_fire) begin
        if (cfg_sel) begin
          div_hero <= cfg_div_clamped;
          cnt_hero <= '0;
        end else begin
          div_game <= cfg_div_clamped;
          cnt_game <= '0;
        end
      end

      // A step restarts both phases, so it overrides a same-edge counter clear.
      if (step_enter) begin
        cnt_hero  <= '0;
        cnt_game  <= '0;
        tick_hero <= 1'b1;
        tick_game <= 1'b1;
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
- Generates single-cycle clock-enable ticks for the hero and game logic from the single system clock. This replaces derived clocks, so all game logic stays on `clk`.
- Provides run, pause and single-step control, plus a handshake for runtime reconfiguration of both tick periods.
- Sits between the top level (board clock, buttons, debug UART) and the hero/game update logic.
- Keeps a frame counter of game ticks.

Parameters:
- CNT_W, 24, width of the period counters and of `cfg_div`.
- HERO_DIV_DEF, 2500000, hero tick period in clk cycles after reset (20 Hz at 50 MHz).
- GAME_DIV_DEF, 1000000, game tick period in clk cycles after reset (50 Hz at 50 MHz).
- FRAME_W, 16, width of `frame_cnt`.

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level input: 1 = run, 0 = pause.
- step  in  1  one-cycle pulse; requests one tick pair while paused.
- cfg_valid  in  1  configuration request.
- cfg_sel  in  1  configuration target: 0 = game period, 1 = hero period.
- cfg_div  in  CNT_W  new period in clk cycles.
- cfg_ready  out  1  configuration can be accepted this cycle.
- tick_hero  out  1  registered one-cycle hero enable.
- tick_game  out  1  registered one-cycle game enable.
- frame_cnt  out  FRAME_W  count of `tick_game` pulses.
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 STEP.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - cnt_hero=cnt_game=0.
  - div_hero=HERO_DIV_DEF, div_game=GAME_DIV_DEF.
  - tick_hero=tick_game=0, frame_cnt=0.
  - Reset overrides everything else, including mid-operation and in STEP.
- FSM transitions:
  - IDLE: run=1 -> RUN; otherwise stay.
  - RUN: run=0 -> PAUSE; otherwise stay.
  - PAUSE: run=1 -> RUN. run=0 and step=1 -> STEP. Otherwise stay. If run=1 and step=1 together, run wins and step is dropped.
  - STEP: lasts exactly one cycle, then always -> PAUSE regardless of inputs.
  - step is ignored in IDLE, RUN and STEP.
- Counting (RUN only), per domain X in {hero, game}:
  - cnt_X==div_X-1: cnt_X<=0 and tick_X<=1.
  - Otherwise: cnt_X<=cnt_X+1 and tick_X<=0.
  - First RUN cycle at t0 with cnt=0 -> first tick is high in cycle t0+div.
  - Subsequent ticks are exactly div cycles apart.
  - Each tick is high for exactly one cycle.
- IDLE and PAUSE: counters hold their value and ticks are 0. Resuming continues from the held count, so no phase loss.
- Entering STEP (the edge PAUSE->STEP):
  - tick_hero<=1 and tick_game<=1, so both are high during the STEP cycle.
  - cnt_hero<=0 and cnt_game<=0.
- Ticks are 0 in every cycle other than RUN wraps and STEP.
- frame_cnt increments by 1 on every edge that sets tick_game<=1, and wraps from 2^FRAME_W-1 to 0.
- Hero and game ticks may coincide. Both are asserted; there is no priority between them.
- Configuration handshake:
  - cfg_ready = 1 in IDLE and PAUSE, 0 in RUN and STEP (combinational from state).
  - Transfer happens when cfg_valid && cfg_ready at a clk edge.
  - On transfer: div_<sel> <= max(cfg_div, 2) and cnt_<sel> <= 0. The other domain is untouched.
  - cfg_div values 0 and 1 are clamped to 2.
  - The requester holds cfg_valid and its payload until ready. The block ignores cfg_valid while ready=0.
  - If a transfer and a PAUSE->RUN transition occur on the same edge, both take effect. Counting uses the new period from the first RUN cycle.
  - A transfer takes priority over a simultaneous step: both occur; the STEP cycle resets counters anyway.

Test Plan (HERO_DIV_DEF=5, GAME_DIV_DEF=3, FRAME_W=4):
- Reset then run=1 at cycle 0: state=RUN at cycle 1. tick_game is high in cycles 4, 7, 10. tick_hero is high in cycles 6, 11. Both are high together at cycle 16. frame_cnt=3 after cycle 10.
- Pause/resume: run=0 for 10 cycles mid-period, with cnt_game=1. Ticks stay 0 throughout. After run=1 returns, the next tick_game arrives 2 cycles after the first RUN cycle. frame_cnt is unchanged while paused.
- Step in PAUSE: one step pulse -> state=STEP for one cycle with tick_hero=tick_game=1. Then state=PAUSE, frame_cnt +1, counters 0. run=1 and step=1 together -> RUN, no STEP.
- Config: in RUN, cfg_valid=1, sel=0, div=4 -> cfg_ready=0 and no transfer. After pause, the transfer completes in one cycle. On resume, tick_game has period 4. cfg_div=1 gives period 2. A hero config leaves the game phase intact.
- frame_cnt wraps: 16 game ticks from 0 -> frame_cnt=0. The 17th tick -> 1.
- rst=1 asserted during STEP and during RUN mid-count: on the next cycle all outputs are at reset values and the periods are back to 5 and 3.
